booth_mul_iter: RTL and testbench
=================================

// Module: booth_mul_iter
// PURPOSE
//  Iterative Booth-2 (radix-4) multiply/accumulate engine for MUL/MLA/UMULL/SMULL/UMLAL/SMLAL.
//  Scans the multiplier G Booth groups per cycle and drives G ppselect instances.
//  Each ppselect returns a 34-bit one's-complement partial product and a cin bit.
//  Sums those into a 64-bit accumulator and stops early once the remaining multiplier bits are pure sign.
//  Sits between the execute-stage operand latches and the result/writeback mux.
// PARAMETERS
//  GROUPS   2   Booth groups retired per CALC cycle; legal values 1,2,3,4,6,17
// PORTS
//  clk      in   1   single clock; all state on posedge
//  reset    in   1   synchronous, active-high
//  start    in   1   request; accepted only when ready=1
//  ready    out  1   engine idle, will accept start
//  op_a     in   32  multiplicand (Rm)
//  op_b     in   32  multiplier (Rs), scanned by Booth groups
//  acc_in   in   64  accumulate operand {RdHi,RdLo}; 32-bit MLA drives {32'b0,Rn}
//  acc_en   in   1   1 = result is product + acc_in
//  sgn      in   1   1 = signed operands, 0 = unsigned
//  busy     out  1   CALC in progress
//  done     out  1   one-cycle pulse: result valid
//  result   out  64  product[63:0] (+acc); 32-bit ops use result[31:0]; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, busy=0, done=0, result=0, internal regs 0.
//  FSM
//   - IDLE -> CALC when start.
//   - CALC -> CALC while not finished.
//   - CALC -> DONE when finished.
//   - DONE -> IDLE unconditionally, next cycle.
//  ready=1 in IDLE only. start seen in CALC or DONE is ignored; nothing is queued.
//  Load (start in IDLE)
//   - mcand33 = {sgn & op_a[31], op_a}.
//   - mplr = {2{sgn & op_b[31]}, op_b, 1'b0}: 35 bits covering groups 0..16.
//   - sum = acc_en ? acc_in : 0; grp = 0.
//  Per CALC cycle, group k = grp .. grp+GROUPS-1
//   - sel_k = mplr[2k+2:2k]; ppselect(mcand33, sel_k) gives pp_k and cin_k.
//   - sum += (sext66(pp_k) + cin_k) << 2k, truncated to 64 bits; grp += GROUPS.
//   - Groups above 16 use sign-fill bits, so they contribute exactly 0. sel 111 gives ~0+1.
//  finished (evaluated on post-update grp)
//   - grp >= 17, or
//   - all mplr bits from bit 2*grp upward equal the extension sign (sgn & op_b[31]).
//   - Unsigned checks against 0.
//  done pulses in the DONE cycle. result updates only on the CALC->DONE transition.
//  Latency: start at cycle 0, first CALC at cycle 1, done at cycle 1+N.
//   - N = CALC cycles, 1..ceil(17/GROUPS).
//   - GROUPS=2: worst case N=9, best case N=1.
//  Overflow: the 64-bit sum wraps mod 2^64, matching ARM UMLAL/SMLAL semantics.
//  Reset mid-CALC or mid-DONE
//   - Returns to IDLE next edge; result cleared to 0; no done pulse.
//   - Same-cycle start ignored while reset=1.
//  op_a/op_b/acc_in are sampled only at accept; they may change during CALC.
// STRUCTURE
//  Shared package mul_pkg
//   - FSM state encoding IDLE/CALC/DONE.
//   - MUL_GROUPS_MAX=17, MPLR_W=35, SUM_W=64.
//  Sub-modules: GROUPS instances of the existing ppselect via generate. No other sub-module.
//  Datapath: GROUPS-input add tree feeding the sum register. Shift amounts come from grp; no shifting of sum.
// TESTING (GROUPS=2)
//  1. Unsigned max: op_a=op_b=FFFFFFFF, sgn=0, acc_en=0.
//     -> result=FFFFFFFE_00000001; N=9 CALC; done at cycle 10.
//  2. Signed early exit: op_a=FFFFFFFF, op_b=00000005, sgn=1.
//     -> result=FFFFFFFF_FFFFFFFB; N=1; done at cycle 2.
//  3. Signed negative multiplier: op_a=7, op_b=FFFFFFFE, sgn=1.
//     -> result=FFFFFFFF_FFFFFFF2; N=1.
//  4. Accumulate: op_a=3, op_b=4, acc_in=00000001_00000000, acc_en=1.
//     -> result=00000001_0000000C.
//  5. Unsigned top bit: op_a=2, op_b=80000000, sgn=0.
//     -> result=00000001_00000000; N=9.
//     Same operands with sgn=1 -> FFFFFFFF_00000000.
//  6. Control: start during CALC ignored; reset at cycle 3 of case 1.
//     -> ready=1, result=0, no done pulse. Back-to-back start the cycle after DONE is accepted.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative Booth-2 multiply/accumulate engine:
// FSM encoding and datapath widths.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  localparam int MUL_GROUPS_MAX = 17;
  localparam int MPLR_W         = 35;
  localparam int SUM_W          = 64;
  localparam int MCAND_W        = 33;
  localparam int PP_W           = 34;
  localparam int GRP_W          = 6;

endpackage

// File: rtl/ppselect.sv
// Radix-4 Booth partial-product selector: returns a one's-complement partial
// product of the 33-bit multiplicand plus the carry-in that completes negation.
module ppselect
  import mul_pkg::*;
(
  input  logic [MCAND_W-1:0] mcand,
  input  logic [2:0]         sel,
  output logic [PP_W-1:0]    pp,
  output logic               cin
);

  logic signed [PP_W-1:0] m1;
  logic signed [PP_W-1:0] m2;

  assign m1 = {mcand[MCAND_W-1], mcand};
  assign m2 = {mcand, 1'b0};

  // Negative selections invert here and rely on cin; 111 is treated as -0.
  always_comb begin
    pp  = '0;
    cin = 1'b0;
    case (sel)
      3'b000:          begin pp = '0;  cin = 1'b0; end
      3'b001, 3'b010:  begin pp = m1;  cin = 1'b0; end
      3'b011:          begin pp = m2;  cin = 1'b0; end
      3'b100:          begin pp = ~m2; cin = 1'b1; end
      3'b101, 3'b110:  begin pp = ~m1; cin = 1'b1; end
      default:         begin pp = '1;  cin = 1'b1; end
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiply/accumulate engine retiring GROUPS Booth
// groups per cycle, with early exit once the remaining multiplier is pure sign.
module booth_mul_iter
  import mul_pkg::*;
#(
  parameter int GROUPS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] acc_in,
  input  logic        acc_en,
  input  logic        sgn,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  localparam int EXT_W = MPLR_W + 2 * GROUPS;

  mul_state_t state_q, state_d;
  logic [MCAND_W-1:0] mcand_q, mcand_d;
  logic [MPLR_W-1:0]  mplr_q, mplr_d;
  logic               sign_q, sign_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   result_q, result_d;
  logic [GRP_W-1:0]   grp_q, grp_d;

  logic [GRP_W-1:0]   grp_next;
  logic [EXT_W-1:0]   mplr_ext;
  logic [SUM_W-1:0]   add_sum;
  logic               all_sign;
  logic               finished;

  logic [2:0]         sel  [GROUPS];
  logic [PP_W-1:0]    pp   [GROUPS];
  logic               cin  [GROUPS];
  logic [SUM_W-1:0]   term [GROUPS];

  // Groups past bit 34 read sign-fill, so they select 000/111 and add zero.
  assign mplr_ext = {{(2 * GROUPS){sign_q}}, mplr_q};
  assign grp_next = grp_q + GRP_W'(GROUPS);

  for (genvar k = 0; k < GROUPS; k++) begin : g_grp
    logic [6:0]              base;
    logic signed [SUM_W-1:0] pp_sx;

    assign base   = 7'(2 * (int'(grp_q) + k));
    assign sel[k] = mplr_ext[base +: 3];
    assign pp_sx  = {{(SUM_W - PP_W){pp[k][PP_W-1]}}, pp[k]};
    assign term[k] = (pp_sx + SUM_W'(cin[k])) << base;

    ppselect u_ppselect (
      .mcand (mcand_q),
      .sel   (sel[k]),
      .pp    (pp[k]),
      .cin   (cin[k])
    );
  end

  always_comb begin
    add_sum = sum_q;
    for (int k = 0; k < GROUPS; k++) begin
      add_sum = add_sum + term[k];
    end
  end

  always_comb begin
    all_sign = 1'b1;
    for (int i = 0; i < MPLR_W; i++) begin
      if ((i >= 2 * int'(grp_next)) && (mplr_q[i] != sign_q)) begin
        all_sign = 1'b0;
      end
    end
    finished = (grp_next >= GRP_W'(MUL_GROUPS_MAX)) || all_sign;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    sign_d   = sign_q;
    sum_d    = sum_q;
    result_d = result_q;
    grp_d    = grp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = {sgn & op_a[31], op_a};
          mplr_d  = {{2{sgn & op_b[31]}}, op_b, 1'b0};
          sign_d  = sgn & op_b[31];
          sum_d   = acc_en ? acc_in : '0;
          grp_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        sum_d = add_sum;
        grp_d = grp_next;
        if (finished) begin
          result_d = add_sum;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      sign_q   <= 1'b0;
      sum_q    <= '0;
      result_q <= '0;
      grp_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      sign_q   <= sign_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      grp_q    <= grp_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Scoreboard bench for booth_mul_iter (GROUPS=2): directed operands with
// hand-computed products and CALC-cycle counts, plus control scenarios.
module tb_booth_mul_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] acc_in;
  logic        acc_en;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    int          n;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_hold = '0;

  booth_mul_iter #(.GROUPS(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ready  (ready),
    .op_a   (op_a),
    .op_b   (op_b),
    .acc_in (acc_in),
    .acc_en (acc_en),
    .sgn    (sgn),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] acc, input logic ae, input logic s,
                       input logic [63:0] res, input int n, input bit push);
    int w;
    w = 0;
    @(negedge clk);
    while (ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ready_wait"}, 64'(ready), 64'd1);
    if (ready !== 1'b1) return;
    chk({nm, " held_result"}, result, exp_hold);
    op_a   = a;
    op_b   = b;
    acc_in = acc;
    acc_en = ae;
    sgn    = s;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_a   = ~a;
    op_b   = ~b;
    acc_in = ~acc;
    acc_en = ~ae;
    sgn    = ~s;
    if (push) begin
      sb.push_back('{res, n, cyc, nm});
      exp_hold = res;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, " result"}, result, e.res);
          chk({e.name, " calc_cycles"}, 64'(cyc - e.acc_cyc), 64'(e.n));
        end
      end
    end
  end

  initial begin
    int w;
    reset  = 1'b1;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    acc_in = '0;
    acc_en = 1'b0;
    sgn    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready",  64'(ready),  64'd1);
    chk("reset busy",   64'(busy),   64'd0);
    chk("reset done",   64'(done),   64'd0);
    chk("reset result", result,      64'd0);
    reset = 1'b0;

    issue("umax",  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 1'b0, 64'hFFFFFFFE_00000001, 9, 1'b1);
    issue("sneg_a", 32'hFFFFFFFF, 32'h00000005, 64'h0, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFB, 1, 1'b1);
    issue("sneg_b", 32'h00000007, 32'hFFFFFFFE, 64'h0, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFF2, 1, 1'b1);
    issue("acc",   32'h00000003, 32'h00000004, 64'h00000001_00000000, 1'b1, 1'b0,
          64'h00000001_0000000C, 1, 1'b1);
    issue("utop",  32'h00000002, 32'h80000000, 64'h0, 1'b0, 1'b0, 64'h00000001_00000000, 9, 1'b1);
    issue("stop",  32'h00000002, 32'h80000000, 64'h0, 1'b0, 1'b1, 64'hFFFFFFFF_00000000, 8, 1'b1);
    issue("smm",   32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 1'b1, 64'h00000000_00000001, 1, 1'b1);
    issue("mid",   32'h00010000, 32'h00010000, 64'h0, 1'b0, 1'b0, 64'h00000001_00000000, 5, 1'b1);
    issue("wrap",  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0,
          64'hFFFFFFFE_00000000, 9, 1'b1);
    issue("smla",  32'hFFFFFFFD, 32'h00000005, 64'h00000000_0000000A, 1'b1, 1'b1,
          64'hFFFFFFFF_FFFFFFFB, 1, 1'b1);
    issue("zero",  32'h000004D2, 32'h00000000, 64'h0, 1'b0, 1'b0, 64'h0, 1, 1'b1);
    issue("acc_off", 32'h00000003, 32'h00000004, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0,
          64'h00000000_0000000C, 1, 1'b1);

    // A start raised while CALC is running must be dropped.
    issue("busy_run", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 1'b0, 64'hFFFFFFFE_00000001, 9, 1'b1);
    @(negedge clk);
    chk("calc busy",  64'(busy),  64'd1);
    chk("calc ready", 64'(ready), 64'd0);
    op_a  = 32'h1;
    op_b  = 32'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in the third cycle of a long multiply, with start held high.
    issue("rst_run", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 1'b0, 64'h0, 9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    op_a  = 32'h5;
    op_b  = 32'h5;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("midreset ready",  64'(ready), 64'd1);
    chk("midreset busy",   64'(busy),  64'd0);
    chk("midreset done",   64'(done),  64'd0);
    chk("midreset result", result,     64'd0);
    exp_hold = '0;
    repeat (12) @(negedge clk);

    issue("after_rst", 32'h00000003, 32'h00000004, 64'h00000001_00000000, 1'b1, 1'b0,
          64'h00000001_0000000C, 1, 1'b1);

    w = 0;
    while (sb.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain pending", 64'(sb.size()), 64'd0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
